parity_serializer: RTL and testbench
====================================

Name: parity_serializer

Overview:
- Transmit-side counterpart of the parity checking path.
- Accepts parallel words over a valid/ready handshake and computes the word's parity code.
- Shifts each word out LSB-first, one bit per accepted beat, followed by a single parity beat.
- Feeds serial links whose receiver deserializes the frame and checks it against the parity code.

Parameters:
- DATA_WIDTH, 8, width of the parallel word; must be >= 1.
- ODD_PARITY, 0, 0 = even parity (code = XOR of data bits); 1 = odd parity (code = inverted XOR).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  parallel word to transmit.
- data_in_valid  input  1  data_in is valid.
- data_in_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current serial bit (data bit or parity bit).
- serial_valid  output  1  serial_out holds a valid beat.
- serial_last  output  1  current beat is the parity beat (end of frame).
- serial_ready  input  1  downstream accepts the current beat.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; shift register = 0; bit counter = 0; parity register = 0.
  - serial_out = 0, serial_valid = 0, serial_last = 0, busy = 0.
  - data_in_ready = 0 while reset is asserted; 1 from the first cycle after deassertion.
- Parity computation: at word acceptance, the parity of data_in is computed combinationally (XOR-reduce, inverted if ODD_PARITY = 1) and registered with the word.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - data_in_ready = 1, serial_valid = 0, serial_out = 0.
  - On data_in_valid & data_in_ready: load shift register with data_in, load parity register, clear counter, go to DATA.
- DATA:
  - serial_valid = 1, serial_out = shift[0], serial_last = 0.
  - On serial_ready: shift right by one and increment counter.
  - When counter == DATA_WIDTH-1 and the beat is accepted, go to PARITY.
- PARITY:
  - serial_valid = 1, serial_out = parity register, serial_last = 1.
  - On serial_ready with no new word accepted: go to IDLE.
- Back-to-back frames:
  - data_in_ready = (state == IDLE) | (state == PARITY & serial_ready). This is a combinational path from serial_ready, and is required.
  - If a word is accepted during the final parity beat, load it and go directly to DATA, so frames run with zero idle cycles.
- Frame length: DATA_WIDTH+1 accepted beats.
- Throughput: one word per DATA_WIDTH+1 cycles at full serial_ready.
- Latency: the first data bit appears on serial_out the cycle after word acceptance.
- Stability rule: while serial_valid & !serial_ready, serial_out and serial_last hold constant and state does not advance.
- data_in changes while not accepted are ignored; data_in is sampled only on the handshake cycle.
- Counter width is max(1, clog2(DATA_WIDTH)).
  - DATA_WIDTH = 1 gives a two-beat frame: one data beat, then the parity beat.
  - The counter never wraps within a frame.
- Reset mid-frame:
  - Asynchronous abort; serial_valid falls immediately and no partial frame resumes.
  - The next accepted word starts a fresh frame at bit 0.
- All outputs are driven from registers except data_in_ready, which is the combinational path described above.

Test Plan:
1. Word 0xA5, even parity, serial_ready held 1 -> 9 beats, serial_out = 1,0,1,0,0,1,0,1 then 0; serial_last high only on beat 9; busy high for 9 cycles.
2. Word 0x07:
   - ODD_PARITY = 0 -> parity beat = 1.
   - ODD_PARITY = 1 -> parity beat = 0.
   - Data beats 1,1,1,0,0,0,0,0 in both cases.
3. Backpressure: 0x3C with serial_ready toggled pseudo-randomly -> serial_out/serial_last stable during every stall; accepted sequence is 0,0,1,1,1,1,0,0 then 0; no beat lost or duplicated.
4. Back-to-back: data_in_valid held with 0xFF then 0x01, serial_ready = 1 -> 18 consecutive valid beats with no gap; data_in_ready pulses on the parity-beat cycle; parities 0 then 1.
5. Reset asserted after 3 accepted beats of 0x5A -> serial_valid = 0 in the same cycle; after deassertion, 0x81 transmits as a clean 9-beat frame (1,0,0,0,0,0,0,1, parity 0).
6. 1000 random words at DATA_WIDTH = 8 and DATA_WIDTH = 1 with random valid/ready -> scoreboard deserializes frames; every word and parity bit matches the model, and serial_last count equals the word count.

Source files
------------

// File: rtl/parity_serializer.sv
// Parity serializer: takes parallel words over valid/ready and shifts them out
// LSB-first, one bit per accepted beat, followed by a single parity beat.
module parity_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  serial_last,
  input  logic                  serial_ready,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bitCount_q, bitCount_d;
  logic                  parity_q, parity_d;
  logic                  serialOut_q, serialOut_d;
  logic                  serialValid_q, serialValid_d;
  logic                  serialLast_q, serialLast_d;
  logic                  busy_q, busy_d;

  logic wordParity;
  logic accept;

  assign wordParity = (^data_in) ^ ODD_PARITY;

  // Ready is combinational from serial_ready so a new word can be taken while
  // the parity beat drains, giving gap-free back-to-back frames.
  assign data_in_ready = !reset &&
                         ((state_q == IDLE) || ((state_q == PARITY) && serial_ready));
  assign accept        = data_in_valid && data_in_ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCount_d = bitCount_q;
    parity_d   = parity_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d    = data_in;
          parity_d   = wordParity;
          bitCount_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (serial_ready) begin
          shift_d = shift_q >> 1;
          if (bitCount_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bitCount_d = bitCount_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (accept) begin
          shift_d    = data_in;
          parity_d   = wordParity;
          bitCount_d = '0;
          state_d    = DATA;
        end else if (serial_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so a stalled beat holds
  // naturally because the next state equals the current one.
  always_comb begin
    serialOut_d   = 1'b0;
    serialValid_d = 1'b0;
    serialLast_d  = 1'b0;
    busy_d        = 1'b0;
    case (state_d)
      DATA: begin
        serialOut_d   = shift_d[0];
        serialValid_d = 1'b1;
        busy_d        = 1'b1;
      end
      PARITY: begin
        serialOut_d   = parity_d;
        serialValid_d = 1'b1;
        serialLast_d  = 1'b1;
        busy_d        = 1'b1;
      end
      default: begin
        serialOut_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bitCount_q    <= '0;
      parity_q      <= 1'b0;
      serialOut_q   <= 1'b0;
      serialValid_q <= 1'b0;
      serialLast_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bitCount_q    <= bitCount_d;
      parity_q      <= parity_d;
      serialOut_q   <= serialOut_d;
      serialValid_q <= serialValid_d;
      serialLast_q  <= serialLast_d;
      busy_q        <= busy_d;
    end
  end

  assign serial_out   = serialOut_q;
  assign serial_valid = serialValid_q;
  assign serial_last  = serialLast_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: three instances (8-bit even, 8-bit odd, 1-bit even)
// checked against a queue of expected beats built from each accepted word.
module tb_parity_serializer;

  logic clock;
  logic reset;

  logic [7:0] dataIn8;
  logic       valid8;
  logic       sready8;
  logic [0:0] dataIn1;
  logic       valid1;
  logic       sready1;

  logic [2:0] dataInReady;
  logic [2:0] serialOut;
  logic [2:0] serialValid;
  logic [2:0] serialLast;
  logic [2:0] busy;

  parity_serializer #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) dutEven (
    .clock(clock), .reset(reset),
    .data_in(dataIn8), .data_in_valid(valid8), .data_in_ready(dataInReady[0]),
    .serial_out(serialOut[0]), .serial_valid(serialValid[0]),
    .serial_last(serialLast[0]), .serial_ready(sready8), .busy(busy[0])
  );

  parity_serializer #(.DATA_WIDTH(8), .ODD_PARITY(1'b1)) dutOdd (
    .clock(clock), .reset(reset),
    .data_in(dataIn8), .data_in_valid(valid8), .data_in_ready(dataInReady[1]),
    .serial_out(serialOut[1]), .serial_valid(serialValid[1]),
    .serial_last(serialLast[1]), .serial_ready(sready8), .busy(busy[1])
  );

  parity_serializer #(.DATA_WIDTH(1), .ODD_PARITY(1'b0)) dutNarrow (
    .clock(clock), .reset(reset),
    .data_in(dataIn1), .data_in_valid(valid1), .data_in_ready(dataInReady[2]),
    .serial_out(serialOut[2]), .serial_valid(serialValid[2]),
    .serial_last(serialLast[2]), .serial_ready(sready1), .busy(busy[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: expected beats as {last, bit}, plus per-instance logs.
  logic [1:0]  expQ [3][$];
  logic [31:0] logVal [3];
  int          logLen [3];
  int          runLen [3];
  int          maxRun [3];
  int          wordCount [3];
  int          lastCount [3];
  int          abortCount [3];
  bit          prevStall [3];
  logic        prevOut [3];
  logic        prevLast [3];

  bit   rndReady8 = 1'b0;
  bit   rndReady1 = 1'b0;
  logic lastAtAccept;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Monitor runs on the falling edge, where inputs for the next rising edge are stable.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      logic       rdy;
      logic       inValid;
      logic [7:0] word;
      int         dw;
      int         qs;
      logic [1:0] e;
      rdy     = (i < 2) ? sready8 : sready1;
      inValid = (i < 2) ? valid8 : valid1;
      word    = (i < 2) ? dataIn8 : {7'b0, dataIn1};
      dw      = (i < 2) ? 8 : 1;
      if (reset) begin
        checkOutput("rstValid", {31'b0, serialValid[i]}, 0);
        checkOutput("rstLast", {31'b0, serialLast[i]}, 0);
        checkOutput("rstOut", {31'b0, serialOut[i]}, 0);
        checkOutput("rstBusy", {31'b0, busy[i]}, 0);
        checkOutput("rstReady", {31'b0, dataInReady[i]}, 0);
        if (expQ[i].size() != 0) abortCount[i]++;
        expQ[i].delete();
        prevStall[i] = 1'b0;
        runLen[i]    = 0;
        logVal[i]    = 0;
        logLen[i]    = 0;
        continue;
      end
      qs = expQ[i].size();
      checkOutput("valid", {31'b0, serialValid[i]}, (qs != 0) ? 1 : 0);
      checkOutput("busy", {31'b0, busy[i]}, (qs != 0) ? 1 : 0);
      checkOutput("inReady", {31'b0, dataInReady[i]},
                  ((qs == 0) || (qs == 1 && rdy)) ? 1 : 0);
      if (prevStall[i]) begin
        checkOutput("stallOut", {31'b0, serialOut[i]}, {31'b0, prevOut[i]});
        checkOutput("stallLast", {31'b0, serialLast[i]}, {31'b0, prevLast[i]});
      end
      if (serialValid[i]) begin
        runLen[i]++;
        if (runLen[i] > maxRun[i]) maxRun[i] = runLen[i];
      end else begin
        runLen[i] = 0;
      end
      if (serialValid[i] && rdy && qs != 0) begin
        e = expQ[i].pop_front();
        checkOutput("bit", {31'b0, serialOut[i]}, {31'b0, e[0]});
        checkOutput("last", {31'b0, serialLast[i]}, {31'b0, e[1]});
        if (logLen[i] < 32) logVal[i] = logVal[i] | (32'(serialOut[i]) << logLen[i]);
        logLen[i]++;
        if (serialLast[i]) lastCount[i]++;
        prevStall[i] = 1'b0;
      end else if (serialValid[i]) begin
        prevStall[i] = 1'b1;
        prevOut[i]   = serialOut[i];
        prevLast[i]  = serialLast[i];
      end else begin
        prevStall[i] = 1'b0;
      end
      if (inValid && dataInReady[i]) begin
        for (int b = 0; b < dw; b++) expQ[i].push_back({1'b0, word[b]});
        expQ[i].push_back({1'b1, 1'(($countones(word) % 2) ^ ((i == 1) ? 1 : 0))});
        wordCount[i]++;
      end
    end
  end

  task automatic waitCycle();
    @(posedge clock);
    #1;
    if (rndReady8) sready8 = 1'($urandom_range(0, 1));
    if (rndReady1) sready1 = 1'($urandom_range(0, 1));
  endtask

  task automatic clearLog();
    for (int i = 0; i < 3; i++) begin
      logVal[i] = 0;
      logLen[i] = 0;
      maxRun[i] = 0;
    end
  endtask

  // Presents one word and waits for its handshake; hold keeps valid asserted.
  task automatic applyStimulus(input bit sel, input logic [7:0] w, input bit hold);
    bit acc;
    int idx;
    acc = 1'b0;
    idx = sel ? 2 : 0;
    if (!sel) begin
      dataIn8 = w;
      valid8  = 1'b1;
    end else begin
      dataIn1 = w[0:0];
      valid1  = 1'b1;
    end
    for (int n = 0; n < 500; n++) begin
      #1;
      acc = dataInReady[idx];
      lastAtAccept = serialLast[idx];
      waitCycle();
      if (acc) break;
    end
    if (!acc) checkOutput("acceptTimeout", {31'b0, dataInReady[idx]}, 1);
    if (!hold) begin
      if (!sel) begin
        valid8  = 1'b0;
        dataIn8 = 8'($urandom);
      end else begin
        valid1  = 1'b0;
        dataIn1 = 1'($urandom);
      end
    end
  endtask

  task automatic waitIdle();
    int n;
    for (n = 0; n < 500; n++) begin
      if (serialValid == 3'b000) break;
      waitCycle();
    end
    if (n == 500) checkOutput("idleTimeout", {29'b0, serialValid}, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      wordCount[i]  = 0;
      lastCount[i]  = 0;
      abortCount[i] = 0;
      runLen[i]     = 0;
      prevStall[i]  = 1'b0;
    end
    clearLog();
    reset   = 1'b1;
    dataIn8 = 8'h00;
    valid8  = 1'b0;
    sready8 = 1'b1;
    dataIn1 = 1'b0;
    valid1  = 1'b0;
    sready1 = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    waitCycle();

    $display("[TB] single word 0xA5");
    clearLog();
    applyStimulus(1'b0, 8'hA5, 1'b0);
    waitIdle();
    checkOutput("a5Even", logVal[0], 32'h0A5);
    checkOutput("a5Odd", logVal[1], 32'h1A5);
    checkOutput("a5Beats", logLen[0], 9);
    checkOutput("a5Run", maxRun[0], 9);

    $display("[TB] word 0x07 even/odd");
    clearLog();
    applyStimulus(1'b0, 8'h07, 1'b0);
    waitIdle();
    checkOutput("w07Even", logVal[0], 32'h107);
    checkOutput("w07Odd", logVal[1], 32'h007);

    $display("[TB] backpressure 0x3C");
    clearLog();
    rndReady8 = 1'b1;
    applyStimulus(1'b0, 8'h3C, 1'b0);
    waitIdle();
    rndReady8 = 1'b0;
    sready8   = 1'b1;
    checkOutput("w3cEven", logVal[0], 32'h03C);
    checkOutput("w3cOdd", logVal[1], 32'h13C);
    checkOutput("w3cBeats", logLen[0], 9);

    $display("[TB] back-to-back 0xFF, 0x01");
    clearLog();
    applyStimulus(1'b0, 8'hFF, 1'b1);
    applyStimulus(1'b0, 8'h01, 1'b0);
    checkOutput("b2bOnParity", {31'b0, lastAtAccept}, 1);
    waitIdle();
    checkOutput("b2bEven", logVal[0], 32'h202FF);
    checkOutput("b2bOdd", logVal[1], 32'h003FF);
    checkOutput("b2bRun", maxRun[0], 18);

    $display("[TB] reset mid-frame");
    clearLog();
    applyStimulus(1'b0, 8'h5A, 1'b0);
    repeat (3) waitCycle();
    checkOutput("preAbortBeats", logLen[0], 3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abortValid", {31'b0, serialValid[0]}, 0);
    checkOutput("abortReady", {31'b0, dataInReady[0]}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    waitCycle();
    clearLog();
    applyStimulus(1'b0, 8'h81, 1'b0);
    waitIdle();
    checkOutput("w81Even", logVal[0], 32'h081);
    checkOutput("w81Beats", logLen[0], 9);

    $display("[TB] random words, 8-bit");
    rndReady8 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) waitCycle();
      applyStimulus(1'b0, 8'($urandom), 1'b0);
    end
    waitIdle();
    rndReady8 = 1'b0;
    sready8   = 1'b1;

    $display("[TB] random words, 1-bit");
    rndReady1 = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 2)) waitCycle();
      applyStimulus(1'b1, 8'($urandom), 1'b0);
    end
    waitIdle();
    rndReady1 = 1'b0;
    sready1   = 1'b1;
    repeat (2) waitCycle();

    for (int i = 0; i < 3; i++) begin
      checkOutput("lastCount", lastCount[i], wordCount[i] - abortCount[i]);
      checkOutput("queueDrained", expQ[i].size(), 0);
    end
    checkOutput("narrowWords", wordCount[2], 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
